// File: rtl/gnr_pkg.sv
// gnr_pkg: shared types and defaults for the GRN attractor sequencer
package gnr_pkg;
  localparam int DEF_CNT_W = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_PSTEP = 3'd4;
  localparam logic [2:0] S_PCMP  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    STEP  = S_STEP,
    CMP   = S_CMP,
    PSTEP = S_PSTEP,
    PCMP  = S_PCMP,
    DONE  = S_DONE
  } state_e;
endpackage

// File: rtl/gnr_step_cnt.sv
// gnr_step_cnt: saturating step counter with clear and budget-reached flag
module gnr_step_cnt #(
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i && !at_max_o) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign cnt_o    = cnt_q;
  assign at_max_o = cnt_q == CNT_W'(MAX_STEPS);
endmodule

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: Floyd tortoise/hare sequencer finding the attractor of a GRN node array
module gnr_attractor_ctrl
  import gnr_pkg::*;
#(
  parameter int N_NODES   = 16,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] seed,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   meet_steps,
  output logic [CNT_W-1:0]   period
);
  state_e             state_q;
  logic               reset_nos_q, start_s0_q, start_s1_q, busy_q, done_q, timeout_q;
  logic [N_NODES-1:0] init_q;
  logic [CNT_W-1:0]   meet_q, period_q, k_cnt, p_cnt;
  logic               eq, go, k_inc, p_inc, k_max, p_max;
  assign eq    = s0_vec == s1_vec;
  assign go    = state_q == IDLE && start;
  // counters advance on entry to STEP/PSTEP so they hold the current index in STEP/CMP and PSTEP/PCMP
  assign k_inc = state_q == LOAD || (state_q == CMP && !eq && !k_max);
  assign p_inc = (state_q == CMP && eq) || (state_q == PCMP && !eq && !p_max);
  gnr_step_cnt #(.CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)) u_k_cnt (
    .clk(clk), .rst(rst), .clr_i(go), .inc_i(k_inc), .cnt_o(k_cnt), .at_max_o(k_max)
  );
  gnr_step_cnt #(.CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)) u_p_cnt (
    .clk(clk), .rst(rst), .clr_i(go), .inc_i(p_inc), .cnt_o(p_cnt), .at_max_o(p_max)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      init_q      <= '0;
      meet_q      <= '0;
      period_q    <= '0;
    end else begin
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q     <= LOAD;
          init_q      <= seed;
          busy_q      <= 1'b1;
          reset_nos_q <= 1'b1;
          timeout_q   <= 1'b0;
          meet_q      <= '0;
          period_q    <= '0;
        end
        LOAD: begin
          state_q    <= STEP;
          start_s1_q <= 1'b1;
        end
        STEP:  state_q <= CMP;
        CMP: if (eq) begin
          meet_q     <= k_cnt;
          state_q    <= PSTEP;
          start_s1_q <= 1'b1;
        end else if (k_max) begin
          timeout_q <= 1'b1;
          period_q  <= '0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end else begin
          // tortoise only starts moving from step 2 so it lags the hare
          state_q    <= STEP;
          start_s1_q <= 1'b1;
          start_s0_q <= 1'b1;
        end
        PSTEP: state_q <= PCMP;
        PCMP: if (eq) begin
          period_q <= p_cnt;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end else if (p_max) begin
          timeout_q <= 1'b1;
          period_q  <= '0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end else begin
          state_q    <= PSTEP;
          start_s1_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign reset_nos  = reset_nos_q;
  assign start_s0   = start_s0_q;
  assign start_s1   = start_s1_q;
  assign init_state = init_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign meet_steps = meet_q;
  assign period     = period_q;
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb_gnr_attractor_ctrl: scoreboard bench, two DUTs (large and tiny step budget) on behavioural node arrays
module tb_gnr_attractor_ctrl;
  typedef struct {
    logic [3:0] seed;
    int meet, per, tmo, cyc, n0, n1;
  } exp_t;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] seed = '0;
  logic       rn [2], st0 [2], st1 [2], bz [2], dn [2], to [2];
  logic [3:0] init [2], s0 [2], s1 [2];
  logic       pass [2];
  logic [15:0] meet [2], per [2];
  logic [3:0] tbl [16];
  int         net_mode = 0;
  int         n_chk = 0, n_pass = 0;
  exp_t       qa[$], qb[$];
  int         act [2], cyc [2], c0 [2], c1 [2];
  always #5 clk = ~clk;
  gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(1000)) dut_a (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .s0_vec(s0[0]), .s1_vec(s1[0]),
    .reset_nos(rn[0]), .start_s0(st0[0]), .start_s1(st1[0]), .init_state(init[0]),
    .busy(bz[0]), .done(dn[0]), .timeout(to[0]), .meet_steps(meet[0]), .period(per[0])
  );
  gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .s0_vec(s0[1]), .s1_vec(s1[1]),
    .reset_nos(rn[1]), .start_s0(st0[1]), .start_s1(st1[1]), .init_state(init[1]),
    .busy(bz[1]), .done(dn[1]), .timeout(to[1]), .meet_steps(meet[1]), .period(per[1])
  );
  function automatic logic [3:0] f(input logic [3:0] x);
    case (net_mode)
      0: return x;
      1: return {x[2:0], x[3]};
      2: return x >> 1;
      default: return tbl[x];
    endcase
  endfunction
  function automatic logic [3:0] fpow(input logic [3:0] x, input int n);
    logic [3:0] y = x;
    for (int j = 0; j < n; j++) y = f(y);
    return y;
  endfunction
  // reference: trajectory arithmetic f^k(x) vs f^(k/2)(x), then orbit length of the meeting point
  function automatic exp_t model(input logic [3:0] sd, input int mx);
    exp_t e;
    int k = 0, p = 0;
    logic [3:0] m;
    e.seed = sd;
    for (int j = 1; j <= mx; j++) if (fpow(sd, j) == fpow(sd, j / 2)) begin k = j; break; end
    if (k == 0) begin
      e.meet = 0; e.per = 0; e.tmo = 1; e.cyc = 2 * mx + 2; e.n1 = mx; e.n0 = mx - 1;
      return e;
    end
    m = fpow(sd, k);
    for (int j = 1; j <= mx; j++) if (fpow(m, j) == m) begin p = j; break; end
    e.meet = k; e.n0 = k - 1;
    e.per  = p;
    e.tmo  = p == 0 ? 1 : 0;
    e.cyc  = 2 * k + 2 + 2 * (p == 0 ? mx : p);
    e.n1   = k + (p == 0 ? mx : p);
    return e;
  endfunction
  task automatic chk(input string nm, input int a, input int x);
    n_chk++;
    if (a == x) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, x);
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rn[i]) begin
        s0[i] <= init[i]; s1[i] <= init[i]; pass[i] <= 1'b1;
      end else begin
        if (st1[i]) s1[i] <= f(s1[i]);
        if (st0[i]) begin
          if (pass[i]) s0[i] <= f(s0[i]);
          pass[i] <= ~pass[i];
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bit   has;
      if (rst) begin
        chk("reset_outputs", int'(rn[i] | st0[i] | st1[i] | bz[i] | dn[i] | to[i] |
            (init[i] != 0) | (meet[i] != 0) | (per[i] != 0)), 0);
        act[i] = 0;
      end else begin
        has = i == 0 ? qa.size() > 0 : qb.size() > 0;
        if (rn[i]) begin
          chk("run_expected", int'(has), 1);
          if (has) begin
            e = i == 0 ? qa[0] : qb[0];
            chk("init_state", int'(init[i]), int'(e.seed));
          end
          chk("load_no_strobe", int'(st0[i] | st1[i]), 0);
          act[i] = 1; cyc[i] = 1; c0[i] = 0; c1[i] = 0;
        end else if (act[i] != 0) begin
          cyc[i]++; c0[i] += int'(st0[i]); c1[i] += int'(st1[i]);
        end
        if (dn[i]) begin
          chk("done_expected", int'(has), 1);
          if (has) begin
            if (i == 0) e = qa.pop_front(); else e = qb.pop_front();
            chk("meet_steps", int'(meet[i]), e.meet);
            chk("period", int'(per[i]), e.per);
            chk("timeout", int'(to[i]), e.tmo);
            chk("done_cycle", cyc[i], e.cyc);
            chk("s0_strobes", c0[i], e.n0);
            chk("s1_strobes", c1[i], e.n1);
            chk("busy_at_done", int'(bz[i]), 1);
          end
          act[i] = 0;
        end
      end
    end
  end
  task automatic run(input logic [3:0] sd, input int mode, input bit poke);
    net_mode = mode;
    qa.push_back(model(sd, 1000));
    qb.push_back(model(sd, 5));
    seed = sd; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 3000 && (qa.size() > 0 || qb.size() > 0); n++) begin
      start = poke && n == 3;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (qa.size() > 0 || qb.size() > 0) begin
      chk("wait_done", 0, 1);
      qa.delete(); qb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run(4'b1010, 0, 1'b0);
    run(4'b0001, 1, 1'b1);
    run(4'b1000, 2, 1'b0);
    // abort during STEP 3: no done may follow
    net_mode = 1;
    qa.push_back(model(4'b0001, 1000));
    qb.push_back(model(4'b0001, 5));
    seed = 4'b0001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    qa.delete(); qb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    run(4'b1010, 0, 1'b0);
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < 16; j++) tbl[j] = 4'($urandom_range(0, 15));
      run(4'($urandom_range(0, 15)), 3, r[0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
